cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit CPU.
- Fetches instructions from memory at the PC address, decodes them, and sequences memory, accumulator and PC updates.
- Drives the PC register's write enable and next value, the unified memory port handshake, and accumulator/ALU controls.
- Instruction format: opcode = instr[7:5], operand address = instr[4:0].

Parameters:
- ADDR_W, 5: PC/memory address width; the only supported value is 5.
- DATA_W, 8: instruction/data word width; the only supported value is 8.
- WAIT_LIMIT, 15: maximum cycles a memory request may wait for mem_ready before FAULT; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears FSM, IR and wait counter.
- run  input  1  level; starts execution from IDLE.
- pc_in  input  ADDR_W  current PC value.
- pc_write  output  1  PC write-enable strobe, one cycle.
- next_pc  output  ADDR_W  value the PC loads when pc_write=1.
- mem_addr  output  ADDR_W  memory address.
- mem_rd  output  1  memory read request.
- mem_wr  output  1  memory write request; write data comes from the accumulator datapath.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_rdata  input  DATA_W  read data, valid when mem_ready=1.
- acc_zero  input  1  accumulator == 0.
- acc_load  output  1  accumulator load strobe, one cycle.
- alu_op  output  2  00 = pass mem_rdata, 01 = add, 10 = sub, 11 = reserved (never driven).
- ir_out  output  DATA_W  instruction register.
- halted  output  1  high in HALT.
- fault  output  1  high in FAULT.

Behaviour:
- Reset values: FSM = IDLE; all outputs 0 (ir_out = 0, next_pc = 0, mem_addr = 0). Assertion at any point (including mid-request) takes effect immediately; requests drop the same instant.
- Opcodes: 000 NOP, 001 LDA, 010 STA, 011 ADD, 100 SUB, 101 JMP, 110 JZ, 111 HLT.
- Registered state and IR; outputs decoded combinationally from state, IR, pc_in, mem_ready and acc_zero.
- IDLE: no requests; run=1 sampled at a clock edge moves to FETCH.
- FETCH: mem_addr = pc_in, mem_rd = 1 held until mem_ready. On the mem_ready cycle, IR <= mem_rdata at the edge, then go to DECODE.
- DECODE (exactly one cycle):
  - NOP: pc_write = 1, next_pc = pc_in + 1, go to FETCH.
  - JMP: pc_write = 1, next_pc = IR[4:0], go to FETCH.
  - JZ: pc_write = 1, next_pc = acc_zero ? IR[4:0] : pc_in + 1, go to FETCH. acc_zero is sampled in DECODE.
  - HLT: no pc_write, go to HALT.
  - LDA/STA/ADD/SUB: go to EXEC.
- EXEC:
  - mem_addr = IR[4:0].
  - LDA/ADD/SUB: mem_rd = 1 until mem_ready. On the ready cycle: acc_load = 1, alu_op = 00/01/10, pc_write = 1, next_pc = pc_in + 1, go to FETCH.
  - STA: mem_wr = 1 until mem_ready. On the ready cycle: pc_write = 1, next_pc = pc_in + 1, go to FETCH.
- PC increment is mod 2^ADDR_W: 31 wraps to 0.
- Strobe rules: pc_write and acc_load are one-cycle strobes. mem_rd and mem_wr are never both 1. mem_ready is ignored when no request is active.
- Wait counter: cleared on entry to FETCH/EXEC; increments each request cycle with mem_ready=0. If it reaches WAIT_LIMIT while mem_ready is still 0, go to FAULT next edge with the request dropped. A mem_ready on the cycle the count equals WAIT_LIMIT completes normally (ready wins).
- HALT and FAULT: terminal until reset; run is ignored. halted and fault are mutually exclusive.
- Latency with zero-wait memory (mem_ready tied high):
  - NOP/JMP/JZ: 2 cycles.
  - LDA/STA/ADD/SUB: 3 cycles.
  - Each wait cycle adds 1.
- run deasserted mid-program has no effect; execution continues until HLT.

Optional Feature:
- Macro: CPU_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit) and state PAUSE.
  - Every transition that would enter FETCH from DECODE or EXEC enters PAUSE instead, with pc_write still issued.
  - IDLE->FETCH is unaffected.
  - PAUSE drives no requests; a step=1 sampled at an edge moves to FETCH.
- When undefined: no step port, no PAUSE state; behaviour exactly as above.

Test Plan:
- Zero-wait memory program LDA 5; ADD 6; STA 7; HLT with mem[5]=3, mem[6]=4:
  - acc_load pulses with alu_op 00 then 01.
  - mem_wr at address 7.
  - halted=1 after 11 cycles from FETCH entry.
  - pc_in ends at 3.
- JMP 0x1F executed at PC 4 -> next_pc = 31. A following NOP at 31 -> next_pc = 0 (wrap).
- JZ 9 at PC 2:
  - acc_zero=1 -> next_pc = 9.
  - acc_zero=0 -> next_pc = 3.
- FETCH with mem_ready delayed 3 cycles -> mem_rd held for 4 cycles and mem_addr stable. With mem_ready never asserted and WAIT_LIMIT=15 -> fault=1 and mem_rd=0 after 16 request cycles.
- Assert reset during EXEC with mem_wr=1 -> mem_wr=0, ir_out=0 immediately. After release with run=1 -> FETCH on the next edge.
- With CPU_SEQ_SINGLE_STEP_EN:
  - NOP -> PAUSE with pc_write pulse.
  - No mem_rd until step=1.
  - FETCH resumes one cycle after step.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: PC, memory-port and accumulator control bundle between
// the sequencer (master) and the CPU datapath/memory (slave).
interface cpu_sequencer_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic              run;
   logic [ADDR_W-1:0] pc_in;
   logic              pc_write;
   logic [ADDR_W-1:0] next_pc;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_wr;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              acc_zero;
   logic              acc_load;
   logic [1:0]        alu_op;
   logic [DATA_W-1:0] ir_out;
   logic              halted;
   logic              fault;
   modport master (
      input  run, pc_in, mem_ready, mem_rdata, acc_zero,
      output pc_write, next_pc, mem_addr, mem_rd, mem_wr, acc_load, alu_op, ir_out, halted, fault
   );
   modport slave (
      output run, pc_in, mem_ready, mem_rdata, acc_zero,
      input  pc_write, next_pc, mem_addr, mem_rd, mem_wr, acc_load, alu_op, ir_out, halted, fault
   );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec control FSM for the 8-bit CPU.
// Define CPU_SEQ_SINGLE_STEP_EN to add the step input and PAUSE state.
module cpu_sequencer #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 8,
   parameter int WAIT_LIMIT = 15
) (
   input logic clk,
   input logic reset,
`ifdef CPU_SEQ_SINGLE_STEP_EN
   input logic step,
`endif
   cpu_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, HALT, FAULT
`ifdef CPU_SEQ_SINGLE_STEP_EN
      , PAUSE
`endif
   } state_t;
`ifdef CPU_SEQ_SINGLE_STEP_EN
   localparam state_t RESUME = PAUSE;
`else
   localparam state_t RESUME = FETCH;
`endif
   localparam logic [2:0] OP_NOP = 3'd0, OP_STA = 3'd2, OP_ADD = 3'd3,
                          OP_SUB = 3'd4, OP_JMP = 3'd5, OP_JZ = 3'd6, OP_HLT = 3'd7;
   state_t            state, next_state;
   logic [DATA_W-1:0] ir;
   logic [7:0]        wait_cnt;
   logic [2:0]        op;
   logic [ADDR_W-1:0] operand, pc_inc;
   logic              req, timed_out, pc_only;
   assign op        = ir[DATA_W-1 -: 3];
   assign operand   = ir[ADDR_W-1:0];
   assign pc_inc    = bus.pc_in + 1'b1;
   assign req       = bus.mem_rd | bus.mem_wr;
   assign timed_out = wait_cnt == 8'(WAIT_LIMIT);
   assign pc_only   = op inside {OP_NOP, OP_JMP, OP_JZ};
   assign bus.ir_out = ir;
   assign bus.halted = state == HALT;
   assign bus.fault  = state == FAULT;
   // The wait counter only runs while a request is stalled, so it is already
   // zero whenever FETCH or EXEC is entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         ir       <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= next_state;
         if (state == FETCH && bus.mem_ready) ir <= bus.mem_rdata;
         wait_cnt <= (req && !bus.mem_ready) ? wait_cnt + 1'b1 : '0;
      end
   end
   always_comb begin
      next_state   = state;
      bus.pc_write = 1'b0;
      bus.next_pc  = '0;
      bus.mem_addr = '0;
      bus.mem_rd   = 1'b0;
      bus.mem_wr   = 1'b0;
      bus.acc_load = 1'b0;
      bus.alu_op   = 2'b00;
      case (state)
         IDLE: next_state = bus.run ? FETCH : IDLE;
         FETCH: begin
            bus.mem_addr = bus.pc_in;
            bus.mem_rd   = 1'b1;
            next_state   = bus.mem_ready ? DECODE : timed_out ? FAULT : FETCH;
         end
         DECODE: begin
            if (pc_only) begin
               bus.pc_write = 1'b1;
               bus.next_pc  = (op == OP_JMP || (op == OP_JZ && bus.acc_zero)) ? operand : pc_inc;
            end
            next_state = (op == OP_HLT) ? HALT : pc_only ? RESUME : EXEC;
         end
         EXEC: begin
            bus.mem_addr = operand;
            bus.mem_wr   = op == OP_STA;
            bus.mem_rd   = op != OP_STA;
            if (bus.mem_ready) begin
               bus.pc_write = 1'b1;
               bus.next_pc  = pc_inc;
               bus.acc_load = op != OP_STA;
               bus.alu_op   = (op == OP_ADD) ? 2'b01 : (op == OP_SUB) ? 2'b10 : 2'b00;
               next_state   = RESUME;
            end else if (timed_out) begin
               next_state = FAULT;
            end
         end
`ifdef CPU_SEQ_SINGLE_STEP_EN
         PAUSE: next_state = step ? FETCH : PAUSE;
`endif
         default: next_state = state;
      endcase
   end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer with a PC register,
// latency-configurable memory and expected strobe events queued per program.
module tb_cpu_sequencer;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic run   = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
   logic step = 1'b1;
   localparam int PROG_CYC = 14;
`else
   localparam int PROG_CYC = 11;
`endif
   typedef struct packed {
      logic [1:0] kind;
      logic [4:0] val;
   } ev_t;
   localparam logic [1:0] EV_PC = 2'd0, EV_ACC = 2'd1, EV_WR = 2'd2;
   ev_t        sb[$];
   int         checks = 0, failures = 0;
   logic [7:0] mem [32];
   logic [4:0] pc, pc_init = '0;
   logic       zf = 1'b0, never = 1'b0;
   int         lat = 0, held = 0;

   cpu_sequencer_if #(.ADDR_W(5), .DATA_W(8)) bus ();

   cpu_sequencer #(.ADDR_W(5), .DATA_W(8), .WAIT_LIMIT(15)) dut (
      .clk(clk),
      .reset(reset),
`ifdef CPU_SEQ_SINGLE_STEP_EN
      .step(step),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   always_comb begin
      bus.run       = run;
      bus.pc_in     = pc;
      bus.acc_zero  = zf;
      bus.mem_rdata = mem[bus.mem_addr];
      bus.mem_ready = (bus.mem_rd || bus.mem_wr) && !never && held >= lat;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pc   <= pc_init;
         held <= 0;
      end else begin
         if (bus.pc_write) pc <= bus.next_pc;
         held <= ((bus.mem_rd || bus.mem_wr) && !bus.mem_ready) ? held + 1 : 0;
      end
   end

   // Observed strobes are matched in a fixed order: acc_load, write, pc_write.
   always @(negedge clk) begin : monitor
      ev_t obs[$];
      ev_t e;
      if (!reset) begin
         obs = {};
         if (bus.mem_rd || bus.mem_wr) begin
            checks++;
            if (bus.mem_rd && bus.mem_wr) begin
               failures++;
               $display("FAIL rd_wr_exclusive rd=%0b wr=%0b required not both", bus.mem_rd, bus.mem_wr);
            end
         end
         if (bus.acc_load) obs.push_back(ev_t'{EV_ACC, {3'b000, bus.alu_op}});
         if (bus.mem_wr && bus.mem_ready) obs.push_back(ev_t'{EV_WR, bus.mem_addr});
         if (bus.pc_write) obs.push_back(ev_t'{EV_PC, bus.next_pc});
         foreach (obs[i]) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected got kind=%0d val=%0d required no event", obs[i].kind, obs[i].val);
            end else begin
               e = sb.pop_front();
               if (obs[i] !== e) begin
                  failures++;
                  $display("FAIL sb_event got kind=%0d val=%0d required kind=%0d val=%0d",
                           obs[i].kind, obs[i].val, e.kind, e.val);
               end
            end
         end
      end
   end

   task automatic boot(input logic [4:0] p0);
      pc_init = p0;
      reset   = 1'b1;
      run     = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      run   = 1'b1;
      @(posedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      run   = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.pc_write, bus.mem_rd, bus.mem_wr, bus.acc_load, bus.halted, bus.fault} !== 6'b0) begin
         failures++;
         $display("FAIL reset_strobes got %b required 000000",
                  {bus.pc_write, bus.mem_rd, bus.mem_wr, bus.acc_load, bus.halted, bus.fault});
      end
      checks++;
      if (bus.ir_out !== 8'h00 || bus.next_pc !== 5'd0 || bus.mem_addr !== 5'd0 || bus.alu_op !== 2'b00) begin
         failures++;
         $display("FAIL reset_values ir=%h next_pc=%0d addr=%0d alu=%b required all 0",
                  bus.ir_out, bus.next_pc, bus.mem_addr, bus.alu_op);
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.mem_rd !== 1'b0) begin
         failures++;
         $display("FAIL idle_without_run mem_rd=%b required 0", bus.mem_rd);
      end
   endtask

   task automatic test_program;
      sb.delete();
      foreach (mem[i]) mem[i] = 8'hE0;
      mem[0] = 8'h25;
      mem[1] = 8'h66;
      mem[2] = 8'h47;
      mem[5] = 8'd3;
      mem[6] = 8'd4;
      lat = 0;
      sb.push_back(ev_t'{EV_ACC, 5'd0});
      sb.push_back(ev_t'{EV_PC, 5'd1});
      sb.push_back(ev_t'{EV_ACC, 5'd1});
      sb.push_back(ev_t'{EV_PC, 5'd2});
      sb.push_back(ev_t'{EV_WR, 5'd7});
      sb.push_back(ev_t'{EV_PC, 5'd3});
      boot(5'd0);
      repeat (PROG_CYC - 1) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.halted !== 1'b0) begin
         failures++;
         $display("FAIL prog_halt_early halted=%b required 0", bus.halted);
      end
      @(negedge clk);
      checks++;
      if (bus.halted !== 1'b1) begin
         failures++;
         $display("FAIL prog_halt_cycle halted=%b required 1", bus.halted);
      end
      checks++;
      if (pc !== 5'd3 || bus.ir_out !== 8'hE0 || sb.size() != 0) begin
         failures++;
         $display("FAIL prog_end pc=%0d ir=%h pending=%0d required pc=3 ir=e0 pending=0", pc, bus.ir_out, sb.size());
      end
      run = 1'b0;
      repeat (3) @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.halted !== 1'b1 || bus.mem_rd !== 1'b0 || bus.fault !== 1'b0) begin
         failures++;
         $display("FAIL halt_terminal halted=%b rd=%b fault=%b required 1 0 0", bus.halted, bus.mem_rd, bus.fault);
      end
   endtask

   task automatic test_jump;
      sb.delete();
      foreach (mem[i]) mem[i] = 8'hE0;
      mem[4]  = 8'hBF;
      mem[31] = 8'h00;
      sb.push_back(ev_t'{EV_PC, 5'd31});
      sb.push_back(ev_t'{EV_PC, 5'd0});
      boot(5'd4);
      for (int i = 0; i < 40 && !bus.halted; i++) @(negedge clk);
      checks++;
      if (bus.halted !== 1'b1 || pc !== 5'd0 || sb.size() != 0) begin
         failures++;
         $display("FAIL jump_wrap halted=%b pc=%0d pending=%0d required 1 0 0", bus.halted, pc, sb.size());
      end
   endtask

   task automatic test_jz(input logic z, input logic [4:0] exp_pc);
      sb.delete();
      foreach (mem[i]) mem[i] = 8'hE0;
      mem[2] = 8'hC9;
      zf = z;
      sb.push_back(ev_t'{EV_PC, exp_pc});
      boot(5'd2);
      for (int i = 0; i < 40 && !bus.halted; i++) @(negedge clk);
      checks++;
      if (bus.halted !== 1'b1 || pc !== exp_pc || sb.size() != 0) begin
         failures++;
         $display("FAIL jz_z%0b halted=%b pc=%0d pending=%0d required 1 %0d 0", z, bus.halted, pc, sb.size(), exp_pc);
      end
      zf = 1'b0;
   endtask

   task automatic test_wait;
      int  cnt;
      logic moved;
      sb.delete();
      foreach (mem[i]) mem[i] = 8'hE0;
      lat   = 3;
      cnt   = 0;
      moved = 1'b0;
      boot(5'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.mem_rd) begin
            cnt++;
            if (bus.mem_addr !== 5'd0) moved = 1'b1;
         end else if (cnt > 0) break;
      end
      checks++;
      if (cnt != 4 || moved) begin
         failures++;
         $display("FAIL wait_fetch rd_cycles=%0d addr_moved=%b required 4 0", cnt, moved);
      end
      for (int i = 0; i < 20 && !bus.halted; i++) @(negedge clk);
      checks++;
      if (bus.halted !== 1'b1) begin
         failures++;
         $display("FAIL wait_halt halted=%b required 1", bus.halted);
      end
      lat = 0;
   endtask

   task automatic test_fault;
      int cnt;
      sb.delete();
      foreach (mem[i]) mem[i] = 8'hE0;
      never = 1'b1;
      cnt   = 0;
      boot(5'd0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.fault) break;
         if (bus.mem_rd) cnt++;
      end
      checks++;
      if (bus.fault !== 1'b1 || cnt != 16) begin
         failures++;
         $display("FAIL fault_timeout fault=%b rd_cycles=%0d required 1 16", bus.fault, cnt);
      end
      checks++;
      if (bus.mem_rd !== 1'b0 || bus.halted !== 1'b0) begin
         failures++;
         $display("FAIL fault_outputs rd=%b halted=%b required 0 0", bus.mem_rd, bus.halted);
      end
      never = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.fault !== 1'b1 || bus.mem_rd !== 1'b0) begin
         failures++;
         $display("FAIL fault_terminal fault=%b rd=%b required 1 0", bus.fault, bus.mem_rd);
      end
   endtask

   task automatic test_reset_exec;
      sb.delete();
      foreach (mem[i]) mem[i] = 8'hE0;
      mem[0] = 8'h47;
      lat = 5;
      boot(5'd0);
      for (int i = 0; i < 20 && !bus.mem_wr; i++) @(negedge clk);
      checks++;
      if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 5'd7) begin
         failures++;
         $display("FAIL exec_write wr=%b addr=%0d required 1 7", bus.mem_wr, bus.mem_addr);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (bus.mem_wr !== 1'b0 || bus.mem_rd !== 1'b0 || bus.ir_out !== 8'h00) begin
         failures++;
         $display("FAIL reset_async wr=%b rd=%b ir=%h required 0 0 00", bus.mem_wr, bus.mem_rd, bus.ir_out);
      end
      @(negedge clk);
      reset = 1'b0;
      run   = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 5'd0) begin
         failures++;
         $display("FAIL restart_fetch rd=%b addr=%0d required 1 0", bus.mem_rd, bus.mem_addr);
      end
      reset = 1'b1;
      lat   = 0;
      @(negedge clk);
   endtask

`ifdef CPU_SEQ_SINGLE_STEP_EN
   task automatic test_step;
      int bad;
      sb.delete();
      foreach (mem[i]) mem[i] = 8'hE0;
      mem[0] = 8'h00;
      step   = 1'b0;
      bad    = 0;
      sb.push_back(ev_t'{EV_PC, 5'd1});
      boot(5'd0);
      repeat (2) @(negedge clk);
      checks++;
      if (bus.pc_write !== 1'b1) begin
         failures++;
         $display("FAIL step_decode pc_write=%b required 1", bus.pc_write);
      end
      repeat (3) begin
         @(negedge clk);
         if (bus.mem_rd !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL step_pause rd_cycles=%0d required 0", bad);
      end
      step = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 5'd1) begin
         failures++;
         $display("FAIL step_resume rd=%b addr=%0d required 1 1", bus.mem_rd, bus.mem_addr);
      end
      for (int i = 0; i < 20 && !bus.halted; i++) @(negedge clk);
      checks++;
      if (bus.halted !== 1'b1 || pc !== 5'd1) begin
         failures++;
         $display("FAIL step_halt halted=%b pc=%0d required 1 1", bus.halted, pc);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_program();
      test_jump();
      test_jz(1'b1, 5'd9);
      test_jz(1'b0, 5'd3);
      test_wait();
      test_fault();
      test_reset_exec();
`ifdef CPU_SEQ_SINGLE_STEP_EN
      test_step();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
